// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical memory line port between I-cache and D-cache.
// Round-robin on ties; the winning request is registered and replayed until pmem_resp.
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  icache_pmem_read,
    input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
    output logic                  icache_pmem_resp,

    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
    output logic                  dcache_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  last_d_q;
    logic                  last_d_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] wdata_d;
    logic                  op_wr_q;
    logic                  op_wr_d;

    logic i_req;
    logic d_req;
    logic pick_i;
    logic pick_d;

    assign i_req = icache_pmem_read;
    assign d_req = dcache_pmem_read | dcache_pmem_write;

    // On a tie the requester that was not served last wins.
    assign pick_i = i_req & (~d_req | last_d_q);
    assign pick_d = d_req & ~pick_i;

    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            op_wr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            op_wr_q  <= op_wr_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        last_d_d         = last_d_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        op_wr_d          = op_wr_q;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = addr_q;
        pmem_wdata       = wdata_q;
        icache_pmem_resp = 1'b0;
        dcache_pmem_resp = 1'b0;

        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    pick_i: begin
                        state_d  = GRANT_I;
                        last_d_d = 1'b0;
                        addr_d   = icache_pmem_address;
                        op_wr_d  = 1'b0;
                    end
                    pick_d: begin
                        state_d  = GRANT_D;
                        last_d_d = 1'b1;
                        addr_d   = dcache_pmem_address;
                        wdata_d  = dcache_pmem_wdata;
                        op_wr_d  = dcache_pmem_write;
                    end
                    default: ;
                endcase
            end
            GRANT_I: begin
                pmem_read  = ~op_wr_q;
                pmem_write = op_wr_q;
                if (pmem_resp) begin
                    icache_pmem_resp = 1'b1;
                    state_d          = IDLE;
                end
            end
            GRANT_D: begin
                pmem_read  = ~op_wr_q;
                pmem_write = op_wr_q;
                if (pmem_resp) begin
                    dcache_pmem_resp = 1'b1;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed vectors against a small latency memory model.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_pmem_arbiter;

    localparam int AW  = 16;
    localparam int LW  = 128;
    localparam int LAT = 4;

    logic          clk;
    logic          rst_n;
    logic          ir;
    logic [AW-1:0] ia;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          dr;
    logic          dw;
    logic [AW-1:0] da;
    logic [LW-1:0] dwd;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic          model_resp;
    logic          stray;

    int checks = 0;
    int errors = 0;

    logic [LW-1:0] mem [logic [AW-1:0]];
    int            cnt;

    localparam logic [LW-1:0] W1 = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
    localparam logic [LW-1:0] W2 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [LW-1:0] W3 = 128'hCAFEBABE_CAFEBABE_CAFEBABE_CAFEBABE;

    assign pmem_resp = model_resp | stray;

    pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .icache_pmem_read    (ir),
        .icache_pmem_address (ia),
        .icache_pmem_rdata   (i_rdata),
        .icache_pmem_resp    (i_resp),
        .dcache_pmem_read    (dr),
        .dcache_pmem_write   (dw),
        .dcache_pmem_address (da),
        .dcache_pmem_wdata   (dwd),
        .dcache_pmem_rdata   (d_rdata),
        .dcache_pmem_resp    (d_resp),
        .pmem_read           (pmem_read),
        .pmem_write          (pmem_write),
        .pmem_address        (pmem_address),
        .pmem_wdata          (pmem_wdata),
        .pmem_rdata          (pmem_rdata),
        .pmem_resp           (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LW-1:0] dflt(input logic [AW-1:0] a);
        return {4{16'hA5A5, a}};
    endfunction

    // Memory: responds LAT cycles after a strobe is first seen.
    always begin
        @(posedge clk);
        #1;
        if (model_resp) begin
            model_resp = 1'b0;
            cnt        = 0;
        end else if (pmem_read || pmem_write) begin
            cnt = cnt + 1;
            if (cnt == LAT) begin
                if (pmem_write)
                    mem[pmem_address] = pmem_wdata;
                pmem_rdata = mem.exists(pmem_address) ?
                             mem[pmem_address] : dflt(pmem_address);
                model_resp = 1'b1;
            end
        end else begin
            cnt = 0;
        end
    end

    task automatic chk(input string tag,
                       input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_resp(output logic gi,
                             output logic gd,
                             output logic [LW-1:0] data);
        gi   = 1'b0;
        gd   = 1'b0;
        data = '0;
        for (int n = 0; n < 30 && !(gi || gd); n++) begin
            @(negedge clk);
            gi = i_resp;
            gd = d_resp;
            data = gi ? i_rdata : d_rdata;
        end
        if (!(gi || gd))
            chk("resp_timeout", 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic          gi;
    logic          gd;
    logic [LW-1:0] rd;

    initial begin
        rst_n      = 1'b0;
        ir         = 1'b0;
        ia         = '0;
        dr         = 1'b0;
        dw         = 1'b0;
        da         = '0;
        dwd        = '0;
        pmem_rdata = '0;
        model_resp = 1'b0;
        stray      = 1'b0;
        cnt        = 0;
        repeat (2) @(negedge clk);

        chk("rst_rd", pmem_read, 1'b0);
        chk("rst_wr", pmem_write, 1'b0);
        chk("rst_addr", pmem_address, 16'h0);
        chk("rst_wdata", pmem_wdata, 128'h0);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        // Lone I-cache read
        ir = 1'b1;
        ia = 16'h0040;
        @(negedge clk);
        chk("t1_rd", pmem_read, 1'b1);
        chk("t1_wr", pmem_write, 1'b0);
        chk("t1_addr", pmem_address, 16'h0040);
        wait_resp(gi, gd, rd);
        chk("t1_who", {gi, gd}, 2'b10);
        chk("t1_data", rd, dflt(16'h0040));
        ir = 1'b0;
        @(negedge clk);
        chk("t1_idle", {pmem_read, pmem_write}, 2'b00);

        // Lone D-cache writeback, then read it back through I
        dw  = 1'b1;
        da  = 16'h1230;
        dwd = W1;
        @(negedge clk);
        chk("t2_wr", pmem_write, 1'b1);
        chk("t2_rd", pmem_read, 1'b0);
        chk("t2_addr", pmem_address, 16'h1230);
        chk("t2_wdata", pmem_wdata, W1);
        wait_resp(gi, gd, rd);
        chk("t2_who", {gi, gd}, 2'b01);
        dw = 1'b0;
        @(negedge clk);
        ir = 1'b1;
        ia = 16'h1230;
        wait_resp(gi, gd, rd);
        chk("t2_rb_who", {gi, gd}, 2'b10);
        chk("t2_rb_data", rd, W1);
        ir = 1'b0;
        @(negedge clk);

        // Simultaneous requests after reset: I first
        do_reset();
        ir = 1'b1;
        ia = 16'h0100;
        dr = 1'b1;
        da = 16'h0200;
        @(negedge clk);
        chk("t3_addr1", pmem_address, 16'h0100);
        wait_resp(gi, gd, rd);
        chk("t3_who1", {gi, gd}, 2'b10);
        chk("t3_data1", rd, dflt(16'h0100));
        ir = 1'b0;
        wait_resp(gi, gd, rd);
        chk("t3_who2", {gi, gd}, 2'b01);
        chk("t3_data2", rd, dflt(16'h0200));
        dr = 1'b0;
        @(negedge clk);
        ir = 1'b1;
        ia = 16'h0110;
        wait_resp(gi, gd, rd);
        chk("t3_who3", {gi, gd}, 2'b10);
        ir = 1'b0;
        @(negedge clk);
        ir = 1'b1;
        ia = 16'h0120;
        dr = 1'b1;
        da = 16'h0220;
        @(negedge clk);
        chk("t3_addr4", pmem_address, 16'h0220);
        wait_resp(gi, gd, rd);
        chk("t3_who4", {gi, gd}, 2'b01);
        dr = 1'b0;
        wait_resp(gi, gd, rd);
        chk("t3_who5", {gi, gd}, 2'b10);
        ir = 1'b0;
        @(negedge clk);

        // Sustained contention: I, D, I, D, I, D
        do_reset();
        ir = 1'b1;
        ia = 16'h0300;
        dr = 1'b1;
        da = 16'h0400;
        for (int k = 0; k < 6; k++) begin
            wait_resp(gi, gd, rd);
            chk($sformatf("t4_who%0d", k), {gi, gd},
                (k % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("t4_data%0d", k), rd,
                (k % 2 == 0) ? dflt(16'h0300) : dflt(16'h0400));
        end
        ir = 1'b0;
        dr = 1'b0;
        @(negedge clk);

        // Address change mid-grant is ignored
        dr = 1'b1;
        da = 16'h0500;
        @(negedge clk);
        chk("t5_addr", pmem_address, 16'h0500);
        da = 16'h0600;
        @(negedge clk);
        chk("t5_hold", pmem_address, 16'h0500);
        wait_resp(gi, gd, rd);
        chk("t5_who", {gi, gd}, 2'b01);
        chk("t5_data", rd, dflt(16'h0500));
        dr = 1'b0;
        @(negedge clk);

        // Stray pmem_resp while idle
        stray = 1'b1;
        #1;
        chk("t6_resp_comb", {i_resp, d_resp}, 2'b00);
        @(negedge clk);
        chk("t6_resp", {i_resp, d_resp}, 2'b00);
        chk("t6_strb", {pmem_read, pmem_write}, 2'b00);
        stray = 1'b0;
        @(negedge clk);

        // D read and write together is a write
        dr  = 1'b1;
        dw  = 1'b1;
        da  = 16'h0700;
        dwd = W2;
        @(negedge clk);
        chk("t7_strb", {pmem_read, pmem_write}, 2'b01);
        wait_resp(gi, gd, rd);
        chk("t7_who", {gi, gd}, 2'b01);
        dr = 1'b0;
        dw = 1'b0;
        @(negedge clk);
        ir = 1'b1;
        ia = 16'h0700;
        wait_resp(gi, gd, rd);
        chk("t7_rb", rd, W2);
        ir = 1'b0;
        @(negedge clk);

        // Reset during a D grant
        dw  = 1'b1;
        da  = 16'h0800;
        dwd = W3;
        @(negedge clk);
        chk("t8_wr", pmem_write, 1'b1);
        rst_n = 1'b0;
        dw    = 1'b0;
        @(negedge clk);
        chk("t8_strb", {pmem_read, pmem_write}, 2'b00);
        chk("t8_resp", {i_resp, d_resp}, 2'b00);
        chk("t8_addr", pmem_address, 16'h0);
        rst_n = 1'b1;
        ir    = 1'b1;
        ia    = 16'h0900;
        dr    = 1'b1;
        da    = 16'h0A00;
        @(negedge clk);
        chk("t8_tie_addr", pmem_address, 16'h0900);
        wait_resp(gi, gd, rd);
        chk("t8_who1", {gi, gd}, 2'b10);
        ir = 1'b0;
        wait_resp(gi, gd, rd);
        chk("t8_who2", {gi, gd}, 2'b01);
        dr = 1'b0;
        @(negedge clk);
        ir = 1'b1;
        ia = 16'h0800;
        wait_resp(gi, gd, rd);
        chk("t8_abandoned", rd, dflt(16'h0800));
        ir = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single 128-bit physical memory line port (pmem_*) between a split instruction cache and data cache.
- Sits between the two caches and physical_memory inside the mp2 top level.
- Grants one requester at a time using round-robin on ties.
- Registers the winning request and drives physical memory from those registers until pmem_resp.
- Returns the response only to the granted cache.

Parameters:
ADDR_WIDTH, 16, byte address width of every pmem address port
LINE_WIDTH, 128, cache line width in bits

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
icache_pmem_read  input  1  I-cache line read request, held until icache_pmem_resp
icache_pmem_address  input  ADDR_WIDTH  I-cache line address
icache_pmem_rdata  output  LINE_WIDTH  line data to I-cache
icache_pmem_resp  output  1  one-cycle completion pulse to I-cache
dcache_pmem_read  input  1  D-cache line read request, held until dcache_pmem_resp
dcache_pmem_write  input  1  D-cache line writeback request, held until dcache_pmem_resp
dcache_pmem_address  input  ADDR_WIDTH  D-cache line address
dcache_pmem_wdata  input  LINE_WIDTH  D-cache writeback data
dcache_pmem_rdata  output  LINE_WIDTH  line data to D-cache
dcache_pmem_resp  output  1  one-cycle completion pulse to D-cache
pmem_read  output  1  read strobe to physical memory
pmem_write  output  1  write strobe to physical memory
pmem_address  output  ADDR_WIDTH  address to physical memory
pmem_wdata  output  LINE_WIDTH  write data to physical memory
pmem_rdata  input  LINE_WIDTH  read data from physical memory
pmem_resp  input  1  completion from physical memory

Behaviour:
- **State machine:** states IDLE, GRANT_I, GRANT_D. There is also a last_grant register (I/D).
- **Reset:** clk edge with rst_n=0 forces the following, overriding any other event:
  - state=IDLE and last_grant=D, so I-cache wins the first tie.
  - Latched address/wdata/op registers clear to 0.
  - All outputs are 0: pmem_read, pmem_write, both resp, and pmem_address/pmem_wdata (driven from the cleared registers).
- **Reset mid-transaction:** any in-flight memory access is abandoned. No resp is generated for it.
- **IDLE, request sampling:**
  - i_req = icache_pmem_read.
  - d_req = dcache_pmem_read | dcache_pmem_write.
  - Only i_req: next GRANT_I.
  - Only d_req: next GRANT_D.
  - Both: grant the requester that is not last_grant.
  - Neither: stay IDLE.
- **IDLE, latching on the granting edge:**
  - Latch the winner's address into addr_q.
  - For D, also latch wdata_q and op_q (write if dcache_pmem_write=1, else read).
  - For I, op_q=read.
  - Update last_grant to the winner.
- **IDLE outputs:** pmem_read=pmem_write=0, and both resp=0.
- **GRANT_I / GRANT_D outputs:**
  - pmem_read = (op_q==read) and pmem_write = (op_q==write).
  - pmem_address=addr_q and pmem_wdata=wdata_q.
  - All are stable for the whole grant, independent of live requester inputs.
- **Grant completion:** the grant holds until the cycle pmem_resp=1. In that same cycle the granted cache's resp = 1 combinationally, and the other resp stays 0. Next state is IDLE.
- **Read data:** icache_pmem_rdata and dcache_pmem_rdata both equal pmem_rdata at all times. Only resp qualifies the data.
- **Latency:** request seen in IDLE at edge N → pmem strobe asserted in cycle N+1. Completion is at memory latency. There is one mandatory IDLE cycle after each resp, which lets the requester drop its request and memory strobes deassert.
- **Fairness:** back-to-back contention alternates I, D, I, D. A pending requester waits at most one other transaction.
- **D-cache read and write both asserted:** treated as write.
- **Request dropped while granted:** this is a protocol violation. The arbiter ignores it and completes the latched access.
- **pmem_resp in IDLE:** ignored, and no resp is forwarded.

Test Plan:
- **Lone I-cache read:** icache read addr 16'h0040 → pmem_read=1, pmem_address=16'h0040 one cycle later. icache_pmem_resp pulses with pmem_resp, carrying rdata=memory line. dcache_pmem_resp stays 0.
- **Lone D-cache writeback:** dcache_pmem_write, addr 16'h1230, wdata 128'hDEADBEEF_...; → pmem_write=1 with matching address/wdata until resp. A later I read of 16'h1230 returns that line.
- **Simultaneous requests after reset:** I@16'h0100 and D read@16'h0200 in the same cycle → I served first, then D. A second simultaneous pair goes D first if I was last served.
- **Sustained contention for 6 transactions:** both requesters re-request continuously → grant order I, D, I, D, I, D. No requester is starved.
- **Input change during grant:** D changes dcache_pmem_address mid-grant → pmem_address stays at the latched value until pmem_resp.
- **Reset mid-transaction:** rst_n=0 for one edge during GRANT_D → next cycle all pmem strobes and resps are 0 and the state is IDLE. A subsequent tie goes to I.
